// File: rtl/mar_mdr_ctrl.sv
// MAR/MDR memory-access controller: latches an address (and store data) on
// ld_mar, holds a memory request until mem_ready or a timeout, and reports
// completion with single-cycle done/err pulses.
module mar_mdr_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_mar,
    input  logic [15:0] mar_in,
    input  logic        rw,
    input  logic [15:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Counter value on the last ACCESS cycle allowed without mem_ready.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        rw_q, rw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Next-state logic: access start, completion, timeout.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_mar) begin
                    mar_d   = mar_in;
                    rw_d    = rw;
                    if (rw) begin
                        mdr_d = wdata;
                    end
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (!rw_q) begin
                        mdr_d = mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    if (!rw_q) begin
                        mdr_d = '1;
                    end
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && rw_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mdr       = mdr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mar_mdr_ctrl.sv
// Bench for mar_mdr_ctrl: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mar_mdr_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_mar = 1'b0;
    logic [15:0] mar_in = '0;
    logic        rw = 1'b0;
    logic [15:0] wdata = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mdr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    mar_mdr_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ld_mar(ld_mar), .mar_in(mar_in), .rw(rw),
        .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mdr(mdr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is "active" with m_k counting which access
    // cycle is in progress (1-based); it ends on ready or after TO cycles.
    bit          m_valid = 0;
    bit          m_active, m_rw, m_done, m_err;
    int unsigned m_k;
    logic [15:0] m_addr, m_mdr;

    // Model advance on each rising edge, compare on each falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1; m_active = 0; m_rw = 0; m_done = 0; m_err = 0;
                m_k = 0; m_addr = '0; m_mdr = '0;
            end else if (m_valid) begin
                m_done = 0; m_err = 0;
                if (!m_active) begin
                    if (ld_mar) begin
                        m_addr = mar_in; m_rw = rw;
                        if (rw) m_mdr = wdata;
                        m_active = 1; m_k = 1;
                    end
                end else if (mem_ready) begin
                    if (!m_rw) m_mdr = mem_rdata;
                    m_done = 1; m_active = 0;
                end else if (m_k == TO) begin
                    if (!m_rw) m_mdr = 16'hFFFF;
                    m_err = 1; m_active = 0;
                end else begin
                    m_k++;
                end
            end
            @(negedge clk);
            if (m_valid) begin
                chk("mem_req",   {31'd0, mem_req},   {31'd0, m_active});
                chk("mem_we",    {31'd0, mem_we},    {31'd0, m_active & m_rw});
                chk("mem_addr",  {16'd0, mem_addr},  {16'd0, m_addr});
                chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_mdr});
                chk("mdr",       {16'd0, mdr},       {16'd0, m_mdr});
                chk("busy",      {31'd0, busy},      {31'd0, m_active});
                chk("done",      {31'd0, done},      {31'd0, m_done});
                chk("err",       {31'd0, err},       {31'd0, m_err});
            end
        end
    end

    // Advance one clock; inputs change and literal checks happen 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
        ld_mar = 1; rw = w; mar_in = a; wdata = d;
        step();
        ld_mar = 0;
    endtask

    int cnt;

    initial begin
        rst = 1;
        step(); step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mdr", {16'd0, mdr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 0;
        step();

        // Read with immediate ready.
        start(0, 16'h3000, 16'h0000);
        chk("rd_req", {31'd0, mem_req}, 32'd1);
        chk("rd_addr", {16'd0, mem_addr}, 32'h3000);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        mem_ready = 1; mem_rdata = 16'hBEEF;
        step();
        mem_ready = 0;
        chk("rd_done", {31'd0, done}, 32'd1);
        chk("rd_mdr", {16'd0, mdr}, 32'hBEEF);
        chk("rd_busy", {31'd0, busy}, 32'd0);
        step();

        // Write with three wait cycles.
        start(1, 16'h4010, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            chk("wr_we", {31'd0, mem_we}, 32'd1);
            chk("wr_wdata", {16'd0, mem_wdata}, 32'h1234);
            if (i == 3) mem_ready = 1;
            step();
        end
        mem_ready = 0;
        chk("wr_done", {31'd0, done}, 32'd1);
        chk("wr_mdr", {16'd0, mdr}, 32'h1234);
        step();

        // Timeout on a read.
        start(0, 16'h0ABC, 16'h0000);
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_done", {31'd0, done}, 32'd0);
        chk("to_mdr", {16'd0, mdr}, 32'hFFFF);
        chk("to_busy", {31'd0, busy}, 32'd0);
        step();

        // Ready on the final allowed cycle wins over timeout.
        start(0, 16'h0123, 16'h0000);
        for (int i = 1; i < TO; i++) step();
        mem_ready = 1; mem_rdata = 16'hA5A5;
        step();
        mem_ready = 0;
        chk("bnd_done", {31'd0, done}, 32'd1);
        chk("bnd_err", {31'd0, err}, 32'd0);
        chk("bnd_mdr", {16'd0, mdr}, 32'hA5A5);

        // Back-to-back: new ld_mar in the done cycle.
        start(1, 16'h7777, 16'h0F0F);
        chk("b2b_req", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr", {16'd0, mem_addr}, 32'h7777);
        mem_ready = 1;
        step();
        mem_ready = 0;

        // Ignored ld_mar, then reset mid-access.
        start(0, 16'h1111, 16'h0000);
        ld_mar = 1; mar_in = 16'h5555;
        step();
        ld_mar = 0;
        chk("ign_addr", {16'd0, mem_addr}, 32'h1111);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        step();
        rst = 0;
        chk("mrst_req", {31'd0, mem_req}, 32'd0);
        chk("mrst_addr", {16'd0, mem_addr}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        step();

        // Randomized traffic; mode selects ready density so timeouts also occur.
        for (int blk = 0; blk < 40; blk++) begin
            int unsigned mode;
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 60; c++) begin
                ld_mar    = ($urandom_range(0, 2) == 0);
                rw        = $urandom_range(0, 1);
                mar_in    = 16'($urandom);
                wdata     = 16'($urandom);
                mem_rdata = 16'($urandom);
                case (mode)
                    0: mem_ready = 1'b0;
                    1: mem_ready = ($urandom_range(0, 19) == 0);
                    2: mem_ready = ($urandom_range(0, 3) == 0);
                    default: mem_ready = $urandom_range(0, 1);
                endcase
                rst = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        rst = 0; ld_mar = 0; mem_ready = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mar_mdr_ctrl.md
MAR_MDR_CTRL -- requirements
Module: mar_mdr_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of ACCESS-state cycles allowed without mem_ready (legal range 2..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ld_mar  input  1  control-store strobe: latch address and start one memory access.
REQ-005 mar_in  input  16  effective address from the address-adder stage.
REQ-006 rw  input  1  0 = read, 1 = write; sampled with ld_mar.
REQ-007 wdata  input  16  store data (SR value); sampled with ld_mar when rw=1.
REQ-008 mem_req  output  1  memory request, held high for the whole access.
REQ-009 mem_we  output  1  write enable, valid while mem_req=1.
REQ-010 mem_addr  output  16  MAR contents.
REQ-011 mem_wdata  output  16  MDR contents.
REQ-012 mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-013 mem_rdata  input  16  read data, valid in the cycle mem_ready=1.
REQ-014 mdr  output  16  MDR register, drives the datapath bus source.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  one-cycle pulse on timeout.

Function
REQ-018 States SHALL be IDLE and ACCESS, encoded in a registered state variable.
REQ-019 In IDLE, ld_mar=1 SHALL load MAR<=mar_in and latch rw, load MDR<=wdata when rw=1 (MDR unchanged when rw=0), clear the timeout counter, and enter ACCESS next cycle.
REQ-020 ld_mar while in ACCESS SHALL be ignored: MAR, MDR, rw and state unchanged.
REQ-021 In ACCESS: mem_req=1, mem_we=latched rw, mem_addr=MAR, mem_wdata=MDR; in IDLE mem_req=0 and mem_we=0.
REQ-022 In ACCESS with mem_ready=1: for a read, MDR<=mem_rdata; in both cases done=1 in the next cycle and state returns to IDLE.
REQ-023 In ACCESS with mem_ready=0, the counter SHALL increment (8-bit, saturating); when it reaches TIMEOUT-1 with mem_ready still 0, the next cycle SHALL be IDLE with err=1, and MDR<=16'hFFFF for reads (unchanged for writes).
REQ-024 mem_ready=1 on the final allowed cycle takes priority over timeout: done, not err.
REQ-025 done and err SHALL be registered, mutually exclusive, and high for exactly one cycle.
REQ-026 Minimum latency: ld_mar at cycle N, mem_req high at N+1; with mem_ready at N+1, done=1 and busy=0 at N+2.
REQ-027 ld_mar in the same cycle that done/err pulses (state IDLE) SHALL start a new access normally, giving back-to-back accesses with one idle cycle.
REQ-028 mem_ready while in IDLE SHALL have no effect.
REQ-029 Address and data SHALL pass unmodified at full 16-bit width; no arithmetic on mar_in.

Reset
REQ-030 rst=1 SHALL force, at the next edge: state=IDLE, MAR=0, MDR=0, counter=0, rw latch=0, so mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mdr=0, busy=0, done=0, err=0.
REQ-031 rst SHALL override all other inputs, including mid-ACCESS: mem_req drops in the cycle after rst is sampled, with no done or err pulse.

Verification
REQ-032 Read: ld_mar=1, rw=0, mar_in=16'h3000; mem_ready=1 with mem_rdata=16'hBEEF on the first ACCESS cycle -> mem_addr=16'h3000, mem_we=0, then done=1 and mdr=16'hBEEF two cycles after ld_mar.
REQ-033 Write: ld_mar=1, rw=1, mar_in=16'h4010, wdata=16'h1234; mem_ready after 3 wait cycles -> mem_we=1 and mem_wdata=16'h1234 for 4 cycles, then done=1 and mdr=16'h1234.
REQ-034 Timeout: TIMEOUT=16 read, mem_ready held 0 -> mem_req high exactly 16 cycles, then err=1, done=0, mdr=16'hFFFF, busy=0.
REQ-035 Boundary: mem_ready=1 on the 16th ACCESS cycle -> done=1, err=0, mdr=mem_rdata.
REQ-036 Ignore and reset: second ld_mar with mar_in=16'h5555 during ACCESS -> mem_addr unchanged; rst mid-ACCESS -> all outputs 0 next cycle, with no done or err.
